// File: rtl/demux1_4_dispatch.sv
// 1-to-4 registered demultiplexer: one producer stream steered by select or round-robin
// into four independent one-entry lane registers, each with a wrapping delivered-beat counter.
module demux1_4_dispatch #(
    parameter int W     = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic [1:0]       S,
    input  logic             rr_mode,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [4*W-1:0]   out_data,
    output logic [1:0]       rr_ptr,
    output logic [4*CNT_W-1:0] cnt
);

    typedef enum logic [1:0] {P0, P1, P2, P3} rr_state_e;

    rr_state_e        rr_q, rr_d;
    logic [3:0]       valid_q, valid_d;
    logic [W-1:0]     data_q [4];
    logic [W-1:0]     data_d [4];
    logic [CNT_W-1:0] cnt_q  [4];
    logic [CNT_W-1:0] cnt_d  [4];

    logic [1:0] sel;
    logic [3:0] free;
    logic [3:0] drain;
    logic       accept;

    // A lane can take a new beat if it is empty or being emptied this very cycle.
    always_comb begin
        sel      = rr_mode ? 2'(rr_q) : S;
        free     = ~valid_q | out_ready;
        drain    = valid_q & out_ready;
        in_ready = reset_n & free[sel];
        accept   = in_valid & in_ready;
    end

    // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latches).
    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < 4; i++) begin
            data_d[i] = data_q[i];
            cnt_d[i]  = cnt_q[i] + {{(CNT_W-1){1'b0}}, drain[i]};
            if (drain[i]) begin
                valid_d[i] = 1'b0;
            end
            if (accept && (sel == i[1:0])) begin
                valid_d[i] = 1'b1;
                data_d[i]  = in_data;
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (accept && rr_mode) begin
            unique case (rr_q)
                P0:      rr_d = P1;
                P1:      rr_d = P2;
                P2:      rr_d = P3;
                default: rr_d = P0;
            endcase
        end
    end

    // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_q    <= P0;
            valid_q <= '0;
            // NOTE: the small data array is reset because out_data is architecturally zero after reset.
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            rr_q    <= rr_d;
            valid_q <= valid_d;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= data_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
        end
    end

    always_comb begin
        out_valid = valid_q;
        rr_ptr    = 2'(rr_q);
        out_data  = '0;
        cnt       = '0;
        for (int i = 0; i < 4; i++) begin
            out_data[i*W +: W]     = data_q[i];
            cnt[i*CNT_W +: CNT_W]  = cnt_q[i];
        end
    end

endmodule

// File: tb/tb_demux1_4_dispatch.sv
// Self-checking bench for demux1_4_dispatch: a per-lane scoreboard queue is filled on
// modelled accepts and popped on drains; every cycle the DUT outputs are compared to it.
module tb_demux1_4_dispatch;

    localparam int W     = 8;
    localparam int CNT_W = 8;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               in_valid;
    logic               in_ready;
    logic [W-1:0]       in_data;
    logic [1:0]         S;
    logic               rr_mode;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
    logic [4*W-1:0]     out_data;
    logic [1:0]         rr_ptr;
    logic [4*CNT_W-1:0] cnt;

    demux1_4_dispatch #(.W(W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .S         (S),
        .rr_mode   (rr_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .rr_ptr    (rr_ptr),
        .cnt       (cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0]     lane_q [4][$];
    logic [CNT_W-1:0] m_cnt  [4];
    logic [1:0]       m_rr;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            lane_q[i].delete();
            m_cnt[i] = '0;
        end
        m_rr = 2'd0;
    endtask

    // Called just after a falling edge with inputs already driven; compares, updates model, advances one cycle.
    task automatic cycle();
        logic [1:0] sel;
        logic       exp_ready;
        #1;
        sel       = rr_mode ? m_rr : S;
        exp_ready = reset_n && ((lane_q[sel].size() == 0) || out_ready[sel]);
        check("in_ready", 64'(in_ready), 64'(exp_ready));
        check("rr_ptr", 64'(rr_ptr), 64'(m_rr));
        for (int i = 0; i < 4; i++) begin
            check($sformatf("out_valid%0d", i), 64'(out_valid[i]), 64'(lane_q[i].size() != 0));
            if (lane_q[i].size() != 0)
                check($sformatf("out_data%0d", i), 64'(out_data[i*W +: W]), 64'(lane_q[i][0]));
            check($sformatf("cnt%0d", i), 64'(cnt[i*CNT_W +: CNT_W]), 64'(m_cnt[i]));
        end
        for (int i = 0; i < 4; i++) begin
            if (out_ready[i] && lane_q[i].size() != 0) begin
                void'(lane_q[i].pop_front());
                m_cnt[i] = m_cnt[i] + 1'b1;
            end
        end
        if (in_valid && exp_ready) begin
            lane_q[sel].push_back(in_data);
            if (rr_mode) m_rr = m_rr + 2'd1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [CNT_W-1:0] cnt_before [4];
    logic [7:0]       rr_beats   [5];

    initial begin
        rr_beats  = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        S         = 2'd0;
        rr_mode   = 1'b0;
        out_ready = 4'b0000;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check("por_out_valid", 64'(out_valid), 64'h0);
        check("por_out_data", 64'(out_data), 64'h0);
        check("por_cnt", 64'(cnt), 64'h0);
        check("por_in_ready", 64'(in_ready), 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        cycle();

        // Select mode: single beat to lane 1, consumers always ready.
        S = 2'd1; out_ready = 4'b1111; in_valid = 1'b1; in_data = 8'hA5;
        cycle();
        in_valid = 1'b0;
        check("t2_out_valid", 64'(out_valid), 64'b0010);
        cycle();
        cycle();
        check("t2_cnt1", 64'(cnt[CNT_W +: CNT_W]), 64'd1);

        // Stall on lane 3: second beat must wait, then drain and refill share one edge.
        S = 2'd3; out_ready = 4'b0111; in_valid = 1'b1; in_data = 8'h11;
        cycle();
        in_data = 8'h22;
        cycle();
        check("t3_in_ready_stalled", 64'(in_ready), 64'h0);
        cycle();
        out_ready = 4'b1111;
        cycle();
        in_valid = 1'b0; out_ready = 4'b0111;
        check("t3_lane3_data", 64'(out_data[3*W +: W]), 64'h22);
        cycle();
        out_ready = 4'b1111;
        cycle();
        cycle();

        // Round-robin, back-to-back beats.
        rr_mode = 1'b1; S = 2'd3;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_data = rr_beats[k];
            cycle();
        end
        in_valid = 1'b0;
        check("t4_lane0_second", 64'(out_data[0 +: W]), 64'h50);
        cycle();
        cycle();
        check("t4_rr_ptr", 64'(rr_ptr), 64'd1);

        // Round-robin held on a stalled lane 2; S must not redirect it.
        in_valid = 1'b1; in_data = 8'h61;
        cycle();
        rr_mode = 1'b0; S = 2'd2; out_ready = 4'b1011; in_data = 8'h62;
        cycle();
        rr_mode = 1'b1; S = 2'd0; in_data = 8'h63;
        repeat (3) cycle();
        check("t5_rr_ptr_held", 64'(rr_ptr), 64'd2);
        check("t5_lane0_unused", 64'(out_valid[0]), 64'h0);
        in_valid = 1'b0; out_ready = 4'b1111;
        cycle();
        cycle();

        // Counter wrap: 256 deliveries on lane 0 bring cnt0 back to its start value.
        for (int i = 0; i < 4; i++) cnt_before[i] = m_cnt[i];
        rr_mode = 1'b0; S = 2'd0; out_ready = 4'b1111;
        for (int k = 0; k < 256; k++) begin
            in_valid = 1'b1; in_data = 8'($urandom);
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        cycle();
        for (int i = 0; i < 4; i++)
            check($sformatf("t6_cnt%0d", i), 64'(cnt[i*CNT_W +: CNT_W]), 64'(cnt_before[i]));

        // Random mix: selects, modes and consumer stalls all varying.
        for (int k = 0; k < 300; k++) begin
            in_valid  = 1'($urandom);
            in_data   = 8'($urandom);
            S         = 2'($urandom);
            rr_mode   = ($urandom_range(0, 3) == 0);
            out_ready = 4'($urandom);
            cycle();
        end

        // Asynchronous reset mid-transfer with lane 2 full and stalled.
        rr_mode = 1'b1; out_ready = 4'b1111; in_valid = 1'b1; in_data = 8'h7E;
        while (m_rr == 2'd0) cycle();
        rr_mode = 1'b0; S = 2'd2; out_ready = 4'b1011; in_data = 8'h3C;
        cycle();
        in_valid = 1'b0;
        check("t1_lane2_full", 64'(out_valid[2]), 64'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t1_out_valid", 64'(out_valid), 64'h0);
        check("t1_cnt", 64'(cnt), 64'h0);
        check("t1_rr_ptr", 64'(rr_ptr), 64'h0);
        check("t1_in_ready", 64'(in_ready), 64'h0);
        check("t1_out_data", 64'(out_data), 64'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 4'b1111;
        cycle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
